// File: rtl/bpm_pkt_pkg.sv
// Shared constants for the BPM Aurora packet format: magic word, packet length,
// header/sum field positions and the parser state encoding.
package bpm_pkt_pkg;

  localparam logic [15:0] BPM_MAGIC     = 16'hA5BE;
  localparam int unsigned BPM_PKT_WORDS = 5;

  localparam int unsigned HDR_MAGIC_MSB = 31;
  localparam int unsigned HDR_MAGIC_LSB = 16;
  localparam int unsigned HDR_EN_BIT    = 15;
  localparam int unsigned HDR_CELL_MSB  = 14;
  localparam int unsigned HDR_CELL_LSB  = 10;
  localparam int unsigned HDR_FOFB_MSB  = 8;
  localparam int unsigned HDR_FOFB_LSB  = 0;

  localparam int unsigned SUM_CRC_BIT   = 31;
  localparam int unsigned SUM_CLIP_BIT  = 30;
  localparam int unsigned SUM_MSB       = 29;
  localparam int unsigned SUM_LSB       = 0;

  typedef enum logic [2:0] {
    ST_HDR     = 3'd0,
    ST_X       = 3'd1,
    ST_Y       = 3'd2,
    ST_S       = 3'd3,
    ST_CRC     = 3'd4,
    ST_DISCARD = 3'd5
  } parser_state_t;

endpackage

// File: rtl/bpm_packet_parser_if.sv
// Aurora RX AXI stream into the BPM parser; no tready, the source never stalls.
interface bpm_packet_parser_if;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;

  modport master (output s_tdata, output s_tvalid, output s_tlast);
  modport slave  (input  s_tdata, input  s_tvalid, input  s_tlast);
endinterface

// File: rtl/bpm_packet_parser.sv
// BPM packet parser: header/X/Y/S/CRC words into registered position outputs.
// Optional BPM_PARSER_STATS_EN adds stats_clear, pkt_count and err_count.
module bpm_packet_parser
  import bpm_pkt_pkg::*;
#(
  parameter logic [15:0] MAGIC     = BPM_MAGIC,
  parameter int unsigned PKT_WORDS = BPM_PKT_WORDS
) (
  input  logic                clk,
  input  logic                rst,
  bpm_packet_parser_if.slave  s_axis,
  output logic                bpm_valid,
  output logic                bpm_fofb_enabled,
  output logic [4:0]          bpm_cell_index,
  output logic [8:0]          bpm_fofb_index,
  output logic [31:0]         bpm_x,
  output logic [31:0]         bpm_y,
  output logic [29:0]         bpm_sum,
  output logic                bpm_crc_fault,
  output logic                bpm_adc_clip,
  output logic                err_magic,
  output logic                err_length
`ifdef BPM_PARSER_STATS_EN
  ,
  input  logic                stats_clear,
  output logic [15:0]         pkt_count,
  output logic [15:0]         err_count
`endif
);

  // The state sequence is hard-wired to header, X, Y, S, CRC.
  if (PKT_WORDS != BPM_PKT_WORDS) begin : g_pkt_words_check
    $error("bpm_packet_parser supports only a 5-word packet");
  end

  parser_state_t state, state_nxt;

  logic        ld_hdr, ld_x, ld_y, ld_s, publish, magic_bad, len_bad;
  logic        magic_ok;

  logic        sh_en, sh_crc, sh_clip;
  logic [4:0]  sh_cell;
  logic [8:0]  sh_fofb;
  logic [31:0] sh_x, sh_y;
  logic [29:0] sh_sum;

  assign magic_ok = (s_axis.s_tdata[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == MAGIC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_HDR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_hdr    = 1'b0;
    ld_x      = 1'b0;
    ld_y      = 1'b0;
    ld_s      = 1'b0;
    publish   = 1'b0;
    magic_bad = 1'b0;
    len_bad   = 1'b0;
    if (s_axis.s_tvalid) begin
      unique case (state)
        ST_HDR: begin
          if (magic_ok) begin
            ld_hdr    = 1'b1;
            state_nxt = ST_X;
          end else begin
            magic_bad = 1'b1;
            // A bad single-beat frame is already over, so nothing to discard.
            state_nxt = s_axis.s_tlast ? ST_HDR : ST_DISCARD;
          end
        end
        ST_X: begin
          if (s_axis.s_tlast) begin
            len_bad   = 1'b1;
            state_nxt = ST_HDR;
          end else begin
            ld_x      = 1'b1;
            state_nxt = ST_Y;
          end
        end
        ST_Y: begin
          if (s_axis.s_tlast) begin
            len_bad   = 1'b1;
            state_nxt = ST_HDR;
          end else begin
            ld_y      = 1'b1;
            state_nxt = ST_S;
          end
        end
        ST_S: begin
          if (s_axis.s_tlast) begin
            len_bad   = 1'b1;
            state_nxt = ST_HDR;
          end else begin
            ld_s      = 1'b1;
            state_nxt = ST_CRC;
          end
        end
        ST_CRC: begin
          if (s_axis.s_tlast) begin
            publish   = 1'b1;
            state_nxt = ST_HDR;
          end else begin
            len_bad   = 1'b1;
            state_nxt = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (s_axis.s_tlast) state_nxt = ST_HDR;
        end
        default: state_nxt = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_en   <= 1'b0;
      sh_cell <= '0;
      sh_fofb <= '0;
      sh_x    <= '0;
      sh_y    <= '0;
      sh_sum  <= '0;
      sh_crc  <= 1'b0;
      sh_clip <= 1'b0;
    end else begin
      if (ld_hdr) begin
        sh_en   <= s_axis.s_tdata[HDR_EN_BIT];
        sh_cell <= s_axis.s_tdata[HDR_CELL_MSB:HDR_CELL_LSB];
        sh_fofb <= s_axis.s_tdata[HDR_FOFB_MSB:HDR_FOFB_LSB];
      end
      if (ld_x) sh_x <= s_axis.s_tdata;
      if (ld_y) sh_y <= s_axis.s_tdata;
      if (ld_s) begin
        sh_crc  <= s_axis.s_tdata[SUM_CRC_BIT];
        sh_clip <= s_axis.s_tdata[SUM_CLIP_BIT];
        sh_sum  <= s_axis.s_tdata[SUM_MSB:SUM_LSB];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bpm_valid        <= 1'b0;
      bpm_fofb_enabled <= 1'b0;
      bpm_cell_index   <= '0;
      bpm_fofb_index   <= '0;
      bpm_x            <= '0;
      bpm_y            <= '0;
      bpm_sum          <= '0;
      bpm_crc_fault    <= 1'b0;
      bpm_adc_clip     <= 1'b0;
      err_magic        <= 1'b0;
      err_length       <= 1'b0;
    end else begin
      bpm_valid  <= publish;
      err_magic  <= magic_bad;
      err_length <= len_bad;
      if (publish) begin
        bpm_fofb_enabled <= sh_en;
        bpm_cell_index   <= sh_cell;
        bpm_fofb_index   <= sh_fofb;
        bpm_x            <= sh_x;
        bpm_y            <= sh_y;
        bpm_sum          <= sh_sum;
        bpm_crc_fault    <= sh_crc;
        bpm_adc_clip     <= sh_clip;
      end
    end
  end

`ifdef BPM_PARSER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (stats_clear) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (bpm_valid)              pkt_count <= pkt_count + 16'd1;
      if (err_magic || err_length) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpm_packet_parser.sv
// Directed bench for bpm_packet_parser: good packets, magic/length errors,
// gapped back-to-back traffic and mid-packet reset.
module tb_bpm_packet_parser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpm_packet_parser_if s_axis ();

  logic        bpm_valid, bpm_fofb_enabled, bpm_crc_fault, bpm_adc_clip;
  logic        err_magic, err_length;
  logic [4:0]  bpm_cell_index;
  logic [8:0]  bpm_fofb_index;
  logic [31:0] bpm_x, bpm_y;
  logic [29:0] bpm_sum;
`ifdef BPM_PARSER_STATS_EN
  logic        stats_clear;
  logic [15:0] pkt_count, err_count;
`endif

  bpm_packet_parser #(.MAGIC(16'hA5BE), .PKT_WORDS(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis           (s_axis),
    .bpm_valid        (bpm_valid),
    .bpm_fofb_enabled (bpm_fofb_enabled),
    .bpm_cell_index   (bpm_cell_index),
    .bpm_fofb_index   (bpm_fofb_index),
    .bpm_x            (bpm_x),
    .bpm_y            (bpm_y),
    .bpm_sum          (bpm_sum),
    .bpm_crc_fault    (bpm_crc_fault),
    .bpm_adc_clip     (bpm_adc_clip),
    .err_magic        (err_magic),
    .err_length       (err_length)
`ifdef BPM_PARSER_STATS_EN
    ,
    .stats_clear      (stats_clear),
    .pkt_count        (pkt_count),
    .err_count        (err_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt = 0, mcnt = 0, lcnt = 0;
  int v0, m0, l0;
  logic [8:0] vq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor on the falling edge, away from the DUT update edge.
  always @(negedge clk) begin
    if (bpm_valid === 1'b1) begin
      vcnt++;
      vq.push_back(bpm_fofb_index);
    end
    if (err_magic === 1'b1)  mcnt++;
    if (err_length === 1'b1) lcnt++;
  end

  task automatic beat(input logic [31:0] d, input logic l);
    @(negedge clk);
    s_axis.s_tdata  = d;
    s_axis.s_tvalid = 1'b1;
    s_axis.s_tlast  = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_axis.s_tvalid = 1'b0;
      s_axis.s_tlast  = 1'b0;
    end
  endtask

  task automatic snap();
    #1;
    v0 = vcnt;
    m0 = mcnt;
    l0 = lcnt;
  endtask

  // Good packet: cell 2, FOFB disabled, y = ~x, S = {crc_fault=1, clip=0, x[29:0]}.
  task automatic packet(input logic [8:0] fofb, input logic [31:0] x, input int unsigned gap);
    logic [31:0] w[5];
    w[0] = {16'hA5BE, 1'b0, 5'd2, 1'b0, fofb};
    w[1] = x;
    w[2] = ~x;
    w[3] = {2'b10, x[29:0]};
    w[4] = 32'h0BAD_C0DE;
    for (int i = 0; i < 5; i++) begin
      idle(int'($urandom_range(gap, 0)));
      beat(w[i], (i == 4));
    end
  endtask

  initial begin
    rst = 1'b1;
    s_axis.s_tdata  = '0;
    s_axis.s_tvalid = 1'b0;
    s_axis.s_tlast  = 1'b0;
`ifdef BPM_PARSER_STATS_EN
    stats_clear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_valid", bpm_valid, 0);
    check("rst_x", bpm_x, 0);
    check("rst_err", {err_magic, err_length}, 0);
    rst = 1'b0;
    idle(1);

    // Scenario 1: reference packet
    beat(32'hA5BE_8403, 0);
    beat(32'd100, 0);
    beat(32'hFFFF_FF38, 0);
    beat(32'h4000_0010, 0);
    beat(32'hDEAD_BEEF, 1);
    check("s1_valid_early", bpm_valid, 0);
    idle(1);
    check("s1_valid", bpm_valid, 1);
    check("s1_x", bpm_x, 100);
    check("s1_y", bpm_y, 32'hFFFF_FF38);
    check("s1_sum", bpm_sum, 30'h10);
    check("s1_clip", bpm_adc_clip, 1);
    check("s1_crc", bpm_crc_fault, 0);
    check("s1_fofb", bpm_fofb_index, 3);
    check("s1_cell", bpm_cell_index, 1);
    check("s1_en", bpm_fofb_enabled, 1);
    idle(1);
    check("s1_pulse_width", bpm_valid, 0);
    check("s1_hold_x", bpm_x, 100);

    // Scenario 2: bad magic, then a good packet
    snap();
    beat(32'h1234_0000, 0);
    beat(32'd1, 0);
    beat(32'd2, 0);
    beat(32'd3, 0);
    beat(32'd4, 1);
    idle(2);
    #1;
    check("s2_magic_cnt", mcnt - m0, 1);
    check("s2_no_valid", vcnt - v0, 0);
    check("s2_no_len", lcnt - l0, 0);
    check("s2_hold_x", bpm_x, 100);
    packet(9'd5, 32'd7, 0);
    idle(2);
    #1;
    check("s2_valid_cnt", vcnt - v0, 1);
    check("s2_fofb", bpm_fofb_index, 5);
    check("s2_x", bpm_x, 7);
    check("s2_y", bpm_y, 32'hFFFF_FFF8);
    check("s2_cell_en", {bpm_cell_index, bpm_fofb_enabled}, {5'd2, 1'b0});
    check("s2_crc_clip", {bpm_crc_fault, bpm_adc_clip}, 2'b10);

    // Scenario 3: tlast on the Y beat
    snap();
    beat(32'hA5BE_0009, 0);
    beat(32'd11, 0);
    beat(32'd22, 1);
    idle(2);
    #1;
    check("s3_len_cnt", lcnt - l0, 1);
    check("s3_no_valid", vcnt - v0, 0);
    check("s3_hold_x", bpm_x, 7);
    check("s3_hold_fofb", bpm_fofb_index, 5);
    packet(9'd10, 32'd33, 0);
    idle(2);
    #1;
    check("s3_recover_cnt", vcnt - v0, 1);
    check("s3_recover_x", bpm_x, 33);

    // Scenario 4: 6-beat packet, tlast only on beat 6
    snap();
    beat(32'hA5BE_01FF, 0);
    beat(32'd1, 0);
    beat(32'd2, 0);
    beat(32'd3, 0);
    beat(32'd4, 0);
    check("s4_len_early", err_length, 0);
    beat(32'd5, 1);
    check("s4_len_at5", err_length, 1);
    idle(2);
    #1;
    check("s4_len_cnt", lcnt - l0, 1);
    check("s4_no_valid", vcnt - v0, 0);
    check("s4_hold_x", bpm_x, 33);
    packet(9'h1FF, 32'd44, 0);
    idle(2);
    #1;
    check("s4_recover_cnt", vcnt - v0, 1);
    check("s4_recover", {bpm_fofb_index, bpm_x}, {9'h1FF, 32'd44});

    // Single-beat bad-magic frame with tlast, immediately followed by a packet
    snap();
    beat(32'hFFFF_0000, 1);
    packet(9'd12, 32'd55, 0);
    idle(2);
    #1;
    check("mt_magic_cnt", mcnt - m0, 1);
    check("mt_len_cnt", lcnt - l0, 0);
    check("mt_valid_cnt", vcnt - v0, 1);
    check("mt_x", bpm_x, 55);

`ifdef BPM_PARSER_STATS_EN
    // Clear coinciding with a bpm_valid pulse wins
    packet(9'd13, 32'd66, 0);
    idle(1);
    stats_clear = 1'b1;
    idle(1);
    stats_clear = 1'b0;
    #1;
    check("st_clear_pkt", pkt_count, 0);
    check("st_clear_err", err_count, 0);
`endif

    // Scenario 5: 8 packets with random gaps
    snap();
    vq.delete();
    for (int i = 0; i < 8; i++) packet(9'(i), 32'(i) * 3 + 1, 2);
    idle(3);
    #1;
    check("s5_valid_cnt", vcnt - v0, 8);
    check("s5_err_cnt", (mcnt - m0) + (lcnt - l0), 0);
    for (int i = 0; i < 8; i++) begin
      if (i < vq.size()) check($sformatf("s5_idx%0d", i), vq[i], i);
      else               check($sformatf("s5_idx%0d_missing", i), 1, 0);
    end
    check("s5_last_x", bpm_x, 22);
    check("s5_last_sum", bpm_sum, 30'd22);
`ifdef BPM_PARSER_STATS_EN
    check("s5_pkt_count", pkt_count, 8);
    check("s5_err_count", err_count, 0);
`endif

    // Scenario 6: reset during the S beat
    snap();
    beat(32'hA5BE_8C21, 0);
    beat(32'd77, 0);
    beat(32'd88, 0);
    @(negedge clk);
    s_axis.s_tdata  = 32'h0000_0123;
    s_axis.s_tvalid = 1'b1;
    s_axis.s_tlast  = 1'b0;
    rst = 1'b1;
    #1;
    check("s6_rst_x", bpm_x, 0);
    check("s6_rst_fofb", bpm_fofb_index, 0);
    check("s6_rst_valid", bpm_valid, 0);
`ifdef BPM_PARSER_STATS_EN
    check("s6_rst_counts", {pkt_count, err_count}, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    s_axis.s_tvalid = 1'b0;
    idle(2);
    #1;
    check("s6_no_valid", vcnt - v0, 0);
    check("s6_hold_zero", bpm_x, 0);
    packet(9'h021, 32'd99, 0);
    idle(2);
    #1;
    check("s6_recover_cnt", vcnt - v0, 1);
    check("s6_recover", {bpm_fofb_index, bpm_x}, {9'h021, 32'd99});
    check("s6_no_err", (mcnt - m0) + (lcnt - l0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bpm_packet_parser.md
BPM_PACKET_PARSER -- requirements
Module: bpm_packet_parser

Interface
REQ-001 The block SHALL have parameter MAGIC, default 16'hA5BE, the required header bits [31:16].
REQ-002 The block SHALL have parameter PKT_WORDS, default 5, the words per packet: header, X, Y, S, CRC.
REQ-003 The block SHALL have port clk  input  1  sole clock.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports s_tdata  input  32, s_tvalid  input  1, s_tlast  input  1; these form the Aurora RX AXI stream, with no tready and no backpressure.
REQ-006 The block SHALL have ports bpm_valid  output  1  (one-cycle pulse, good packet) and bpm_fofb_enabled  output  1.
REQ-007 The block SHALL have ports bpm_cell_index  output  5, bpm_fofb_index  output  9, bpm_x  output  32, bpm_y  output  32.
REQ-008 The block SHALL have ports bpm_sum  output  30, bpm_crc_fault  output  1, bpm_adc_clip  output  1.
REQ-009 The block SHALL have ports err_magic  output  1 and err_length  output  1; each is a one-cycle error pulse.

Function
REQ-010 The block SHALL implement the states HDR, X, Y, S, CRC and DISCARD; a beat is a cycle with s_tvalid=1, and cycles with s_tvalid=0 SHALL leave all state unchanged.
REQ-011 In HDR, a beat with s_tdata[31:16]==MAGIC SHALL capture fofb_enabled=[15], cell_index=[14:10] and fofb_index=[8:0] into shadow registers and move to X.
REQ-012 In HDR, a beat with a magic mismatch SHALL pulse err_magic on the next cycle and move to DISCARD; if that beat also has s_tlast=1, the block SHALL stay in HDR.
REQ-013 The states X, Y and S SHALL capture the full word, the full word, and {crc_fault=[31], clip=[30], sum=[29:0]} into shadows respectively, then advance to the next state.
REQ-014 In CRC, a beat with s_tlast=1 SHALL copy all shadows to the bpm_* outputs and pulse bpm_valid, both on the next cycle (latency 1 after the last beat), and SHALL return to HDR.
REQ-015 The block SHALL NOT check the CRC word.
REQ-016 A beat with s_tlast=1 in X, Y or S SHALL pulse err_length and return to HDR; the bpm_* outputs SHALL NOT change.
REQ-017 A beat with s_tlast=0 in CRC SHALL pulse err_length and move to DISCARD.
REQ-018 In DISCARD, beats SHALL be dropped until a beat with s_tlast=1, which returns the block to HDR with no further error pulse.
REQ-019 The bpm_* data outputs SHALL hold their last good packet until the next good packet.
REQ-020 For back-to-back packets with no idle cycle, each SHALL produce its own bpm_valid pulse.

Reset
REQ-021 Asserting rst SHALL force state HDR, all outputs to 0, and all shadows to 0.
REQ-022 Reset asserted mid-packet SHALL abort the packet with no bpm_valid pulse; after rst deasserts, the next beat SHALL be treated as a header.

Configuration
REQ-023 With BPM_PARSER_STATS_EN defined, the block SHALL add input stats_clear (1) and outputs pkt_count (16) and err_count (16).
REQ-024 pkt_count SHALL increment on each bpm_valid pulse, and err_count SHALL increment on each err_magic or err_length pulse; both SHALL wrap modulo 2^16.
REQ-025 When stats_clear and an increment occur in the same cycle, the clear SHALL win; rst SHALL clear both counters.
REQ-026 Without BPM_PARSER_STATS_EN, the stats ports and counters SHALL be absent, with identical behaviour otherwise.

Structure
REQ-027 A shared package bpm_pkt_pkg SHALL hold MAGIC, PKT_WORDS, the header and sum field bit positions, and the parser state encoding, for reuse by the traffic generator and the bench.
REQ-028 The block SHALL be a single module with no sub-module; the optional stats counters SHALL be inline.

Verification
REQ-029 Bench scenario 1: header 0xA5BE_8403 (enabled=1, cell=1, fofb=3), X=100, Y=-200, S=0x4000_0010, CRC with tlast -> one cycle later bpm_valid=1, x=100, y=0xFFFFFF38, sum=0x10, clip=1, crc_fault=0, fofb_index=3, cell_index=1.
REQ-030 Bench scenario 2: header 0x1234_0000 followed by 4 beats, the last with tlast -> err_magic pulses once, no bpm_valid, and the following good packet is parsed.
REQ-031 Bench scenario 3: tlast on the Y beat -> err_length pulse, outputs unchanged, next beat treated as header.
REQ-032 Bench scenario 4: 6-beat packet with tlast only on beat 6 -> err_length at beat 5, DISCARD, no bpm_valid, recovery on the next packet.
REQ-033 Bench scenario 5: 8 back-to-back packets with fofb_index 0..7 and random tvalid gaps -> 8 bpm_valid pulses carrying indices 0..7 in order; with stats enabled, pkt_count=8 and err_count=0.
REQ-034 Bench scenario 6: rst asserted during the S beat -> no bpm_valid, outputs 0, and the next full packet is parsed correctly.
